// File: rtl/adder_pkg.sv
// Shared helpers for the adder arbiter: index width sizing and operand
// extension for the exact (DATA_WIDTH+1)-bit sum.
package adder_pkg;

   localparam int MAX_DW = 64;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   function automatic int id_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   // Caller passes the operand zero-padded; bits at and above w get the fill.
   function automatic logic [MAX_DW:0] ext_operand(input logic [MAX_DW-1:0] v,
                                                   input int w, input bit sgn);
      logic [MAX_DW:0] r;
      r = {1'b0, v};
      for (int b = 0; b <= MAX_DW; b++)
         if (b >= w) r[b] = sgn & v[w-1];
      return r;
   endfunction

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin pick: rotate requests so the pointer sits at
// bit 0, take the lowest set bit, then rotate the winner back.
module rr_picker
   import adder_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   logic [NUM_REQ-1:0] rot;
   int                 src;
   int                 hit;
   int                 sel;

   always_comb begin
      rot   = '0;
      src   = 0;
      hit   = 0;
      sel   = 0;
      any_o = 1'b0;
      gnt_o = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         src = j + int'(ptr_i);
         if (src >= NUM_REQ) src = src - NUM_REQ;
         rot[j] = req_i[src];
      end
      // Descending scan so the lowest rotated position wins.
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            any_o = 1'b1;
            hit   = j;
         end
      end
      sel = hit + int'(ptr_i);
      if (sel >= NUM_REQ) sel = sel - NUM_REQ;
      idx_o      = IW'(sel);
      gnt_o[sel] = any_o;
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered adder among NUM_REQ requesters with round-robin
// grant; result carries the requester index and honours backpressure.
module adder_arbiter
   import adder_pkg::*;
#(
   parameter  bit SIGNED     = 1'b1,
   parameter  int DATA_WIDTH = 16,
   parameter  int NUM_REQ    = 4,
   localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data1_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data2_i,
   output logic [DATA_WIDTH:0]           data_o,
   output logic [ID_WIDTH-1:0]           id_o,
   output logic                          valid_o,
   input  logic                          ready_i
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH:0]   data_q, data_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

   logic                  slot_free;
   logic [NUM_REQ-1:0]    req_m;
   logic [NUM_REQ-1:0]    gnt;
   logic [ID_WIDTH-1:0]   gnt_idx;
   logic                  gnt_any;
   logic [DATA_WIDTH-1:0] op1, op2;
   logic [MAX_DW:0]       ext1, ext2, sum_full;
   logic                  unused_sum_hi;

   // Requests are masked while the output slot is busy or reset is held,
   // so the picker never grants into a full register.
   assign slot_free = !valid_q || ready_i;
   assign req_m     = req_valid_i & {NUM_REQ{slot_free & rst_n}};

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req_i (req_m),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign req_ready_o = gnt;

   assign op1      = data1_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign op2      = data2_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign ext1     = ext_operand(MAX_DW'(op1), DATA_WIDTH, SIGNED);
   assign ext2     = ext_operand(MAX_DW'(op2), DATA_WIDTH, SIGNED);
   assign sum_full = ext1 + ext2;
   assign unused_sum_hi = ^sum_full[MAX_DW:DATA_WIDTH+1];

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      if (gnt_any) begin
         valid_d = 1'b1;
         data_d  = sum_full[DATA_WIDTH:0];
         id_d    = gnt_idx;
         ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign id_o    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench: a signed and an unsigned instance share stimulus; a
// round-robin reference model predicts grants and sums.
module tb_adder_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] d1, d2;
   logic            ready;

   logic [N-1:0]    rdy_s, rdy_u;
   logic [DW:0]     data_s, data_u;
   logic [1:0]      id_s, id_u;
   logic            vld_s, vld_u;

   adder_arbiter #(.SIGNED(1'b1), .DATA_WIDTH(DW), .NUM_REQ(N)) dut_s (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy_s),
      .data1_i(d1), .data2_i(d2), .data_o(data_s), .id_o(id_s),
      .valid_o(vld_s), .ready_i(ready));

   adder_arbiter #(.SIGNED(1'b0), .DATA_WIDTH(DW), .NUM_REQ(N)) dut_u (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy_u),
      .data1_i(d1), .data2_i(d2), .data_o(data_u), .id_o(id_u),
      .valid_o(vld_u), .ready_i(ready));

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [DW:0] s;
      logic [DW:0] u;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_ptr = 0;
   bit   m_valid = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW:0] sum_of(input int i, input bit sgn);
      logic [DW-1:0] a, b;
      int            r;
      a = d1[i*DW +: DW];
      b = d2[i*DW +: DW];
      if (sgn) r = int'($signed(a)) + int'($signed(b));
      else     r = int'(a) + int'(b);
      return r[DW:0];
   endfunction

   task automatic set_all(input logic [DW-1:0] a, input logic [DW-1:0] b);
      for (int i = 0; i < N; i++) begin
         d1[i*DW +: DW] = a;
         d2[i*DW +: DW] = b;
      end
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) begin
         d1[i*DW +: DW] = DW'($urandom);
         d2[i*DW +: DW] = DW'($urandom);
      end
   endtask

   // Reference model: search upward from the pointer with wrap.
   always @(negedge clk) begin
      logic [N-1:0] eg;
      int           g;
      int           j;
      eg = '0;
      g  = -1;
      if (!rst_n) begin
         chk("rst_ready", {rdy_s, rdy_u}, '0);
         chk("rst_valid", {vld_s, vld_u}, '0);
      end else begin
         if (!m_valid || ready)
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (g < 0 && req_valid[j]) g = j;
            end
         if (g >= 0) eg[g] = 1'b1;
         chk("grant_s", rdy_s, eg);
         chk("grant_u", rdy_u, eg);
         chk("valid_s", vld_s, m_valid);
         chk("valid_u", vld_u, m_valid);
         if (g >= 0) begin
            sb.push_back('{g, sum_of(g, 1'b1), sum_of(g, 1'b0)});
            m_ptr   = (g + 1) % N;
            m_valid = 1'b1;
         end else if (m_valid && ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Monitor: the presented result must match the oldest unaccepted grant.
   always @(negedge clk) begin
      if (rst_n && vld_s) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=valid expected=none t=%0t", $time);
         end else begin
            chk("id_s", id_s, sb[0].id);
            chk("id_u", id_u, sb[0].id);
            chk("data_s", data_s, sb[0].s);
            chk("data_u", data_u, sb[0].u);
            if (ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      req_valid = '1;
      ready     = 1'b1;
      rand_data();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_data", {data_s, data_u}, '0);
      chk("rst_id", {id_s, id_u}, '0);
      chk("rst_vld", {vld_s, vld_u}, '0);
      chk("rst_rdy", rdy_s, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("first_grant", rdy_s, 4'b0001);

      repeat (8) begin
         @(posedge clk);
         #1 rand_data();
      end

      @(posedge clk);
      #1 set_all(16'h8000, 16'h8000);
      repeat (3) @(posedge clk);
      #1 set_all(16'h7FFF, 16'h0001);
      repeat (3) @(posedge clk);

      #1 ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 ready = 1'b1;
      req_valid = 4'b0100;
      rand_data();
      @(posedge clk);
      #1 req_valid = 4'b1010;
      repeat (4) @(posedge clk);
      #1 req_valid = 4'b1001;
      @(posedge clk);
      #1 req_valid = 4'b0010;
      @(posedge clk);

      repeat (300) begin
         #1;
         req_valid = N'($urandom);
         ready     = ($urandom_range(0, 3) != 0);
         rand_data();
         @(posedge clk);
      end

      #1 req_valid = '1;
      ready = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_vld", {vld_s, vld_u}, '0);
      chk("async_data", {data_s, data_u}, '0);
      chk("async_id", {id_s, id_u}, '0);
      chk("async_rdy", rdy_s, '0);
      sb.delete();
      m_ptr   = 0;
      m_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("ptr_after_rst", rdy_s, 4'b0001);
      repeat (4) @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(posedge clk);
      #1 chk("drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
